// File: rtl/equalization_table_builder_pkg.sv
// Shared definitions for the histogram-equalization table builder.
// Holds the bus geometry, lane layout, FSM state encoding and default
// scratch-SRAM base addresses used by the top and its lane multiplier.
package equalization_table_builder_pkg;

  localparam int AddressSize = 16;
  localparam int DataBusSize = 128;
  localparam int LaneCount   = 4;
  localparam int LaneWidth   = 32;

  localparam logic [14:0] DefaultCountBase     = 15'h040;
  localparam logic [14:0] DefaultEqualizedBase = 15'h000;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/equalization_table_builder_eq_scale_lane.sv
// Purpose: map one cumulative bin count to an 8-bit equalized level.
// Latency: combinational; Backpressure: none (pure function of cdf_i).
// Ports: cdf_i = cumulative count for the bin, eq_o = equalized level.
module eq_scale_lane
  import equalization_table_builder_pkg::*;
#(
  parameter int          CdfWidth = 19,
  parameter logic [31:0] Scale    = 32'd3565159
) (
  input  logic [CdfWidth-1:0] cdf_i,
  output logic [7:0]          eq_o
);

  localparam int ProdWidth = CdfWidth + LaneWidth;

  logic [ProdWidth-1:0] prod;

  // Scale is 2^32*255/TotalPixels, so bits [39:32] are the level; any bit
  // above 39 means the count overflowed the image size and the level clips.
  assign prod = ProdWidth'(cdf_i) * ProdWidth'(Scale);
  assign eq_o = (|prod[ProdWidth-1:40]) ? 8'hFF : prod[39:32];

endmodule

// File: rtl/equalization_table_builder.sv
// Purpose: read a 256-bin histogram from scratch SRAM, build the CDF and
//          write back a 256-entry equalization table (16 bytes per word).
// Latency: 64 reads on consecutive cycles; table word w written 2 cycles
//          after histogram word 4w+3 is sampled; flag rises after write 16.
// Backpressure: none; Control[0] low or reset aborts and zeroes outputs.
// Ports: clock/reset (sync, active high), Control[0]=run, Control[1]=bank,
//        ReadAddressScratch/ReadBusScratch = histogram read port (1-cycle),
//        WriteAddressScratch/WriteBusScratch/WriteEnableScratch = table write,
//        flag = run complete.
module equalization_table_builder
  import equalization_table_builder_pkg::*;
#(
  parameter logic [14:0] CountBaseAddress     = DefaultCountBase,
  parameter logic [14:0] EqualizedBaseAddress = DefaultEqualizedBase,
  parameter logic [18:0] TotalPixels          = 19'd307200,
  parameter logic [31:0] Scale                = 32'd3565159
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             Control,
  output logic [AddressSize-1:0] ReadAddressScratch,
  input  logic [DataBusSize-1:0] ReadBusScratch,
  output logic [AddressSize-1:0] WriteAddressScratch,
  output logic [DataBusSize-1:0] WriteBusScratch,
  output logic                   WriteEnableScratch,
  output logic                   flag
);

  // Accumulator is just wide enough to count every pixel of the image.
  localparam int CdfWidth = $clog2(int'(TotalPixels) + 1);

  logic [1:0]             state_q, state_d;
  logic [5:0]             rd_idx_q, rd_idx_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [AddressSize-1:0] rd_addr_q, rd_addr_d;

  logic                                 smp_vld_q, smp_vld_d;
  logic [1:0]                           smp_idx_q, smp_idx_d;
  logic [LaneCount-1:0][CdfWidth-1:0]   smp_lane_q, smp_lane_d;

  logic [CdfWidth-1:0]    cdf_q, cdf_d;
  logic [DataBusSize-1:0] grp_q, grp_d;
  logic                   grp_full_q, grp_full_d;

  logic [4:0]             wr_cnt_q, wr_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [AddressSize-1:0] wr_addr_q, wr_addr_d;
  logic [DataBusSize-1:0] wr_dat_q, wr_dat_d;

  logic [LaneCount-1:0][CdfWidth-1:0] cdf_lane;
  logic [LaneCount-1:0][7:0]          eq_lane;

  logic [AddressSize-1:0] rd_base;
  logic [AddressSize-1:0] wr_base;
  logic                   unused_lane_hi;

  assign rd_base = {Control[1], CountBaseAddress};
  assign wr_base = {Control[1], EqualizedBaseAddress};

  // Lane counts beyond the accumulator width are dropped on purpose.
  always_comb begin
    unused_lane_hi = 1'b0;
    for (int n = 0; n < LaneCount; n++) begin
      unused_lane_hi ^= ^ReadBusScratch[n*LaneWidth+CdfWidth +: LaneWidth-CdfWidth];
    end
  end

  // Running sum in lane order: each lane's CDF includes its own bin.
  always_comb begin
    logic [CdfWidth-1:0] acc;
    acc = cdf_q;
    for (int n = 0; n < LaneCount; n++) begin
      acc         = acc + smp_lane_q[n];
      cdf_lane[n] = acc;
    end
  end

  for (genvar n = 0; n < LaneCount; n++) begin : g_lane
    eq_scale_lane #(
      .CdfWidth(CdfWidth),
      .Scale   (Scale)
    ) u_lane (
      .cdf_i(cdf_lane[n]),
      .eq_o (eq_lane[n])
    );
  end

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    rd_vld_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    cdf_d      = cdf_q;
    grp_d      = grp_q;
    wr_cnt_d   = wr_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_dat_d   = wr_dat_q;

    case (state_q)
      StIdle: begin
        state_d   = StRead;
        rd_idx_d  = 6'd0;
        rd_vld_d  = 1'b1;
        rd_addr_d = rd_base;
      end
      StRead: begin
        rd_idx_d  = rd_idx_q + 6'd1;
        rd_vld_d  = 1'b1;
        rd_addr_d = rd_base + AddressSize'(rd_idx_d);
        if (rd_idx_q == 6'd62) state_d = StDrain;
      end
      StDrain: begin
        if (wr_cnt_q == 5'd16) state_d = StDone;
      end
      default: ;
    endcase

    // Stage 1: capture the read data one cycle after its address.
    smp_vld_d = rd_vld_q;
    smp_idx_d = rd_idx_q[1:0];
    for (int n = 0; n < LaneCount; n++) begin
      smp_lane_d[n] = ReadBusScratch[n*LaneWidth +: CdfWidth];
    end

    // Stage 2: accumulate and place the four levels into the group word.
    grp_full_d = smp_vld_q && (smp_idx_q == 2'd3);
    if (smp_vld_q) begin
      cdf_d = cdf_lane[LaneCount-1];
      for (int n = 0; n < LaneCount; n++) begin
        grp_d[(int'(smp_idx_q)*LaneCount + n)*8 +: 8] = eq_lane[n];
      end
    end

    // Stage 3: a completed group becomes one table write.
    wr_en_d = grp_full_q;
    if (grp_full_q) begin
      wr_dat_d  = grp_q;
      wr_addr_d = wr_base + AddressSize'(wr_cnt_q[3:0]);
      wr_cnt_d  = wr_cnt_q + 5'd1;
    end

    // Dropping run enable abandons everything in flight.
    if (!Control[0]) begin
      state_d    = StIdle;
      rd_idx_d   = '0;
      rd_vld_d   = 1'b0;
      rd_addr_d  = '0;
      smp_vld_d  = 1'b0;
      smp_idx_d  = '0;
      smp_lane_d = '0;
      cdf_d      = '0;
      grp_d      = '0;
      grp_full_d = 1'b0;
      wr_cnt_d   = '0;
      wr_en_d    = 1'b0;
      wr_addr_d  = '0;
      wr_dat_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_idx_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
      smp_vld_q  <= 1'b0;
      smp_idx_q  <= '0;
      smp_lane_q <= '0;
      cdf_q      <= '0;
      grp_q      <= '0;
      grp_full_q <= 1'b0;
      wr_cnt_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      rd_vld_q   <= rd_vld_d;
      rd_addr_q  <= rd_addr_d;
      smp_vld_q  <= smp_vld_d;
      smp_idx_q  <= smp_idx_d;
      smp_lane_q <= smp_lane_d;
      cdf_q      <= cdf_d;
      grp_q      <= grp_d;
      grp_full_q <= grp_full_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_dat_q   <= wr_dat_d;
    end
  end

  assign ReadAddressScratch  = rd_addr_q;
  assign WriteAddressScratch = wr_addr_q;
  assign WriteBusScratch     = wr_dat_q;
  assign WriteEnableScratch  = wr_en_q;
  assign flag                = (state_q == StDone);

endmodule

// File: tb/tb_equalization_table_builder.sv
// Purpose: randomized and directed bench for the equalization table builder.
// Latency: expects 64 back-to-back reads, writes at read-cycle 4w+6, flag at 67.
// Backpressure: none; scratch read port modelled with one-cycle latency.
module tb_equalization_table_builder;

  localparam logic [31:0] SCALE = 32'd3565159;

  typedef struct packed {
    logic [15:0]  addr;
    logic [127:0] dat;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [1:0]   Control;
  logic [15:0]  ReadAddressScratch;
  logic [127:0] ReadBusScratch;
  logic [15:0]  WriteAddressScratch;
  logic [127:0] WriteBusScratch;
  logic         WriteEnableScratch;
  logic         flag;

  logic [31:0] hist [256];
  exp_t        sb [$];
  int          checks   = 0;
  int          failures = 0;

  equalization_table_builder dut (
    .clock              (clock),
    .reset              (reset),
    .Control            (Control),
    .ReadAddressScratch (ReadAddressScratch),
    .ReadBusScratch     (ReadBusScratch),
    .WriteAddressScratch(WriteAddressScratch),
    .WriteBusScratch    (WriteBusScratch),
    .WriteEnableScratch (WriteEnableScratch),
    .flag               (flag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Scratch SRAM: data for the registered address is on the bus by the next edge.
  always_comb begin : rd_model
    int off;
    ReadBusScratch = {4{32'hDEADBEEF}};
    off = int'(ReadAddressScratch) - int'({Control[1], 15'h040});
    if (off >= 0 && off < 64) begin
      for (int n = 0; n < 4; n++) ReadBusScratch[32*n +: 32] = hist[off*4 + n];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_addr"}, 128'(ReadAddressScratch), 128'd0);
    chk({tag, "_wr_addr"}, 128'(WriteAddressScratch), 128'd0);
    chk({tag, "_wr_bus"}, WriteBusScratch, 128'd0);
    chk({tag, "_wr_en"}, 128'(WriteEnableScratch), 128'd0);
    chk({tag, "_flag"}, 128'(flag), 128'd0);
  endtask

  // Reference: CDF of 19-bit truncated counts, level = floor(cdf*Scale/2^32), clipped.
  task automatic build_expected(input bit c1);
    logic [18:0]  cdf;
    logic [63:0]  prod;
    logic [7:0]   lvl [256];
    exp_t         e;
    cdf = '0;
    for (int b = 0; b < 256; b++) begin
      cdf  = cdf + hist[b][18:0];
      prod = 64'(cdf) * 64'(SCALE);
      lvl[b] = (prod >= (64'd1 << 40)) ? 8'hFF : prod[39:32];
    end
    for (int w = 0; w < 16; w++) begin
      e.addr = {c1, 15'h000} + 16'(w);
      for (int j = 0; j < 16; j++) e.dat[8*j +: 8] = lvl[16*w + j];
      sb.push_back(e);
    end
  endtask

  task automatic fill(input int mode);
    for (int b = 0; b < 256; b++) begin
      case (mode)
        0: hist[b] = 32'($urandom_range(0, 2400));
        1: hist[b] = (b % 3 == 0) ? $urandom : 32'($urandom_range(0, 5000));
        default: hist[b] = 32'd0;
      endcase
    end
  endtask

  // Monitor: every presented write is checked against the next expected word.
  always @(negedge clock) begin
    if (WriteEnableScratch === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %h with no expected write pending", WriteAddressScratch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 128'(WriteAddressScratch), 128'(e.addr));
        chk("wr_data", WriteBusScratch, e.dat);
      end
    end
  end

  task automatic run_test(input bit c1);
    logic [15:0] rbase;
    rbase = {c1, 15'h040};
    build_expected(c1);
    Control = {c1, 1'b1};
    for (int i = 0; i < 72; i++) begin
      @(negedge clock);
      if (i < 64) chk("rd_addr_seq", 128'(ReadAddressScratch), 128'(16'(rbase + 16'(i))));
      chk("wr_en_timing", 128'(WriteEnableScratch),
          128'((i >= 6 && i <= 66 && ((i - 6) % 4) == 0) ? 1 : 0));
      chk("flag_timing", 128'(flag), 128'((i >= 67) ? 1 : 0));
    end
    chk("all_writes_seen", 128'(sb.size()), 128'd0);
    Control = {c1, 1'b0};
    @(negedge clock);
    chk_zero("disable");
  endtask

  initial begin
    reset   = 1'b1;
    Control = 2'b00;
    fill(2);
    repeat (3) @(negedge clock);
    chk_zero("reset");
    Control = 2'b01;
    @(negedge clock);
    chk_zero("reset_prio");
    Control = 2'b00;
    reset   = 1'b0;
    @(negedge clock);
    chk_zero("idle");

    // All pixels in bin 0.
    fill(2); hist[0] = 32'd307200;
    run_test(1'b0);
    // All pixels in bin 128.
    fill(2); hist[128] = 32'd307200;
    run_test(1'b0);
    // Uniform histogram.
    for (int b = 0; b < 256; b++) hist[b] = 32'd1200;
    run_test(1'b0);
    // Upper scratch bank.
    fill(0);
    run_test(1'b1);
    // Random histograms, including oversized counts that wrap and clip.
    for (int t = 0; t < 4; t++) begin
      fill(t % 2);
      run_test(1'($urandom_range(0, 1)));
    end

    // Reset right after the fifth write.
    fill(0);
    build_expected(1'b0);
    Control = 2'b01;
    for (int i = 0; i <= 22; i++) @(negedge clock);
    chk("fifth_write_seen", 128'(WriteEnableScratch), 128'd1);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk_zero("mid_reset");
    end
    Control = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    chk_zero("post_reset");

    // Abort after 30 reads, then a full fresh run.
    fill(1);
    build_expected(1'b0);
    Control = 2'b01;
    for (int i = 0; i < 30; i++) @(negedge clock);
    chk("abort_rd_addr", 128'(ReadAddressScratch), 128'(16'h040 + 16'd29));
    Control = 2'b00;
    @(negedge clock);
    chk_zero("abort");
    sb.delete();
    fill(0);
    run_test(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/equalization_table_builder.md
EQUALIZATION_TABLE_BUILDER -- requirements
Module: equalization_table_builder

Interface
REQ-001 Parameter CountBaseAddress, 15'h040: base address of the histogram words in scratch SRAM.
REQ-002 Parameter EqualizedBaseAddress, 15'h000: base address of the equalized-table words in scratch SRAM.
REQ-003 Parameter TotalPixels, 19'd307200: total pixel count of the image (640x480).
REQ-004 Parameter Scale, 32'd3565159: equals ceil(2^32*255/TotalPixels).
REQ-005 Port clock, input, 1: the single clock; all logic on posedge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port Control, input, 2: [0] run enable from control block; [1] scratch-bank MSB prepended to both base addresses.
REQ-008 Port ReadAddressScratch, output, 16: histogram read address.
REQ-009 Port ReadBusScratch, input, 128: histogram read data, four 32-bit lanes; lane n in bits [32n+31:32n].
REQ-010 Port WriteAddressScratch, output, 16: equalized-table write address.
REQ-011 Port WriteBusScratch, output, 128: 16 equalized bytes; byte j in bits [8j+7:8j].
REQ-012 Port WriteEnableScratch, output, 1: write strobe.
REQ-013 Port flag, output, 1: completion flag to control block.

Function
REQ-014 Histogram layout: word r (r=0..63) at {Control[1],CountBaseAddress}+r holds bin 4r+n in lane n.
REQ-015 Table layout: word w (w=0..15) at {Control[1],EqualizedBaseAddress}+w holds the equalized value of pixel 16w+j in byte j.
REQ-016 Scratch read latency is one cycle: data for an address registered at edge N is sampled at edge N+1.
REQ-017 FSM states: IDLE, READ, DRAIN, DONE.
REQ-018 Transitions: IDLE->READ when Control[0]=1; READ->DRAIN after address r=63 is issued; DRAIN->DONE after the last table write; DONE holds while Control[0]=1.
REQ-019 In READ, addresses r=0..63 are issued on 64 consecutive cycles, starting the first cycle after Control[0] rises.
REQ-020 Running CDF: 19-bit accumulator, cleared in IDLE.
REQ-021 Per received word, the four lanes are accumulated in lane order (0..3); cdf(b) includes bin b.
REQ-022 Lane counts are truncated to 19 bits before addition.
REQ-023 Equalized value: eq(b) = bits [39:32] of the 51-bit product cdf(b)*Scale, saturated to 8'hFF if the product is >= 2^40.
REQ-024 Each group of 4 received words (16 bins) is registered into one output word.
REQ-025 Output word w is written with WriteEnableScratch=1 for exactly one cycle, two cycles after the data of histogram word 4w+3 is sampled.
REQ-026 Exactly 16 writes occur per run, in ascending w, with WriteEnableScratch=0 in all other cycles.
REQ-027 flag=1 in DONE, starting the cycle after the 16th write; flag=0 otherwise.
REQ-028 Control[0]=0 at any time returns the FSM to IDLE next edge, clears the CDF and word counters, and forces all outputs to 0.
REQ-029 Control[1] is sampled every cycle; a change mid-run is not supported, and the outputs in that case are undefined but bounded to the 16 addresses.
REQ-030 Control[0] held at 1 in DONE starts no new run; a new run requires Control[0] to fall and rise again.

Reset
REQ-031 reset=1 forces state IDLE and the CDF and counters to 0.
REQ-032 reset=1 forces ReadAddressScratch=0, WriteAddressScratch=0, WriteBusScratch=0, WriteEnableScratch=0 and flag=0 at the next edge.
REQ-033 reset has priority over Control[0].
REQ-034 Reset mid-run discards partial results; no further write is issued.

Structure
REQ-035 The shared project package holds: AddressSize=16, DataBusSize=128, the FSM state encoding, and the default base addresses.
REQ-036 One sub-module, eq_scale_lane, performs the 19x32 multiply and saturation for one bin; it is instantiated 4 times, one per lane.

Verification
REQ-037 All 307200 pixels in bin 0 (others 0) -> 16 writes at 0x0000..0x000F, every byte 8'hFF, flag=1 the cycle after the last write.
REQ-038 Bin 128=307200, others 0 -> words 0..7 all 8'h00, words 8..15 all 8'hFF.
REQ-039 Uniform histogram of 1200 per bin -> byte 0 of word 0 = 8'h00, byte 15 of word 15 = 8'hFF, values monotonic non-decreasing across all 256 entries.
REQ-040 Control=2'b11 -> reads at 0x8040..0x807F and writes at 0x8000..0x800F.
REQ-041 reset asserted after the 5th write -> all outputs 0 next edge, no further writes, flag stays 0.
REQ-042 Control[0] dropped after 30 reads then re-raised -> a full fresh run of 64 reads and 16 writes with correct data.
